instr_word_builder: RTL and testbench

//   Inverse of the instruction field splitter: packs MIPS fields (opcode, rs, rt,
//   rd, shamt, funct, imm, target) into 32-bit R/I/J instruction words.

---
 rtl/instr_word_builder.sv | 116 +++++++++++
 tb/tb_instr_word_builder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_word_builder.sv
// Program loader: packs MIPS R/I/J fields into 32-bit words and writes them to
// consecutive imem word addresses over a valid/ready handshake.
module instr_word_builder #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned LAST_ADDR = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LAST_ADDR);

   // StDrain: last word is on the write port, input already closed
   typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              accept;
   logic              legal;
   logic              is_last;
   logic [31:0]       word;

   assign accept  = in_valid & in_ready;
   assign legal   = (fmt != 2'b11);
   assign is_last = (ptr_q == LAST_PTR);

   always_comb begin
      word = 32'h0;
      unique case (fmt)
         2'b00:   word = {opcode, rs, rt, rd, shamt, funct};
         2'b01:   word = {opcode, rs, rt, imm};
         2'b10:   word = {opcode, target};
         default: word = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (start) begin
            // restart from any state; a same-cycle accept is dropped
            state_q  <= StLoad;
            ptr_q    <= BASE_PTR;
            count    <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
         end else begin
            unique case (state_q)
               StLoad: begin
                  if (accept && legal) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= ptr_q;
                     mem_wdata <= word;
                     count     <= count + 1'b1;
                     if (!is_last) ptr_q <= ptr_q + 1'b1;
                  end
                  if (accept && !legal) err <= 1'b1;
                  if (accept && legal && (is_last || finish)) begin
                     state_q  <= StDrain;
                     in_ready <= 1'b0;
                  end else if (finish) begin
                     state_q  <= StDone;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end
               StDrain: begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
               StIdle, StDone: begin
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_word_builder.sv
// Self-checking bench for instr_word_builder: vector table plus scoreboard of expected writes.
module tb_instr_word_builder;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] word;
   } vec_t;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, start3 = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic [1:0]  fmt = '0;
   logic [5:0]  opcode = '0, funct = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
   logic [15:0] imm = '0;
   logic [25:0] target = '0;

   logic        in_ready, mem_we, busy, done, err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [8:0]  count;
   logic        in_ready3, mem_we3, busy3, done3, err3;
   logic [7:0]  mem_addr3;
   logic [31:0] mem_wdata3;
   logic [8:0]  count3;

   int   ntot = 0;
   int   npass = 0;
   wr_t  q0[$];
   wr_t  q3[$];
   vec_t tbl[8];

   always #5 clk = ~clk;

   instr_word_builder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
      .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .funct(funct), .imm(imm), .target(target), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .busy(busy), .done(done),
      .err(err)
   );

   instr_word_builder #(.ADDR_W(8), .BASE_ADDR(0), .LAST_ADDR(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .finish(finish), .in_valid(in_valid),
      .in_ready(in_ready3), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .funct(funct), .imm(imm), .target(target), .mem_we(mem_we3),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .count(count3), .busy(busy3),
      .done(done3), .err(err3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic unexpected(input string name, input logic [7:0] a, input logic [31:0] d);
      ntot++;
      $display("FAIL %s: unexpected write got addr %0h data %08h, expected no write", name, a, d);
   endtask

   // Scoreboards: every write strobe must match the oldest expected write
   always @(posedge clk) begin
      #1;
      if (mem_we) begin
         if (q0.size() == 0) unexpected("dut write", mem_addr, mem_wdata);
         else begin
            wr_t e;
            e = q0.pop_front();
            check("dut write addr", 64'(mem_addr), 64'(e.addr));
            check("dut write data", 64'(mem_wdata), 64'(e.data));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (mem_we3) begin
         if (q3.size() == 0) unexpected("dut3 write", mem_addr3, mem_wdata3);
         else begin
            wr_t e;
            e = q3.pop_front();
            check("dut3 write addr", 64'(mem_addr3), 64'(e.addr));
            check("dut3 write data", 64'(mem_wdata3), 64'(e.data));
         end
      end
   end

   function automatic vec_t mk(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                               input logic [4:0] t, input logic [4:0] d, input logic [4:0] sa,
                               input logic [5:0] fn, input logic [15:0] im,
                               input logic [25:0] tg, input logic [31:0] w);
      vec_t v;
      v.fmt = f; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.sh = sa;
      v.fn = fn; v.imm = im; v.tgt = tg; v.word = w;
      return v;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input vec_t v);
      fmt = v.fmt; opcode = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.sh;
      funct = v.fn; imm = v.imm; target = v.tgt;
      in_valid = 1'b1;
   endtask

   task automatic push0(input int a, input logic [31:0] d);
      wr_t e;
      e.addr = 8'(a); e.data = d;
      q0.push_back(e);
   endtask

   initial begin
      vec_t bad;
      tbl[0] = mk(2'b00, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 16'h0,    26'h0,       32'h012A4020);
      tbl[1] = mk(2'b01, 6'h08, 5'd9,  5'd8,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h21280005);
      tbl[2] = mk(2'b10, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0,    26'h0100000, 32'h08100000);
      tbl[3] = mk(2'b00, 6'h00, 5'd0,  5'd9,  5'd8,  5'd4,  6'h00, 16'hFFFF, 26'h3FFFFFF, 32'h00094100);
      tbl[4] = mk(2'b01, 6'h23, 5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'hFFFC, 26'h0,       32'h8FA8FFFC);
      tbl[5] = mk(2'b10, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0,    26'h3FFFFFF, 32'h0FFFFFFF);
      tbl[6] = mk(2'b01, 6'h0D, 5'd1,  5'd2,  5'd31, 5'd31, 6'h3F, 16'hABCD, 26'h3FFFFFF, 32'h3422ABCD);
      tbl[7] = mk(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000001, 32'h08000001);
      bad    = mk(2'b11, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0);

      // reset state
      cyc(); cyc();
      check("reset mem_we", 64'(mem_we), 64'd0);
      check("reset mem_addr", 64'(mem_addr), 64'd0);
      check("reset count", 64'(count), 64'd0);
      check("reset busy/done/err/in_ready", 64'({busy, done, err, in_ready}), 64'd0);
      rst_n = 1'b1;
      cyc();
      check("idle in_ready", 64'(in_ready), 64'd0);

      // back-to-back vectors, in_ready held high
      start = 1'b1; cyc(); start = 1'b0;
      check("start busy", 64'(busy), 64'd1);
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i]);
         check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
         push0(i, tbl[i].word);
         cyc();
         check($sformatf("vec%0d count", i), 64'(count), 64'(i + 1));
      end
      in_valid = 1'b0; cyc();
      check("table count", 64'(count), 64'd8);

      // illegal fmt between two legal words
      start = 1'b1; cyc(); start = 1'b0;
      check("restart count", 64'(count), 64'd0);
      drive(tbl[0]); push0(0, tbl[0].word); cyc();
      drive(bad); cyc();
      drive(tbl[2]); push0(1, tbl[2].word); cyc();
      in_valid = 1'b0; cyc();
      check("illegal err", 64'(err), 64'd1);
      check("illegal count", 64'(count), 64'd2);
      check("illegal addr", 64'(mem_addr), 64'd1);
      finish = 1'b1; cyc(); finish = 1'b0;
      check("finish done", 64'({done, busy, in_ready}), 64'b100);
      check("done holds err/count", 64'({err, count}), 64'({1'b1, 9'd2}));
      cyc();
      check("done holds addr", 64'(mem_addr), 64'd1);

      // finish together with third accept
      start = 1'b1; cyc(); start = 1'b0;
      check("start clears done/err", 64'({done, err, busy}), 64'b001);
      for (int i = 0; i < 3; i++) begin
         drive(tbl[3 + i]);
         finish = (i == 2);
         push0(i, tbl[3 + i].word);
         cyc();
      end
      finish = 1'b0; in_valid = 1'b0;
      check("finish+accept ready drops", 64'({in_ready, done}), 64'b00);
      cyc();
      check("finish+accept done", 64'(done), 64'd1);
      check("finish+accept count", 64'(count), 64'd3);
      check("finish+accept addr", 64'(mem_addr), 64'd2);

      // restart with a write still on the port
      start = 1'b1; cyc(); start = 1'b0;
      drive(tbl[6]); push0(0, tbl[6].word); cyc();
      drive(tbl[7]); start = 1'b1; cyc(); start = 1'b0; in_valid = 1'b0;
      check("restart reinit count", 64'(count), 64'd0);
      check("restart busy", 64'(busy), 64'd1);
      drive(tbl[1]); push0(0, tbl[1].word); cyc();
      in_valid = 1'b0; cyc();
      check("restart write count", 64'(count), 64'd1);
      check("restart write addr", 64'(mem_addr), 64'd0);

      // async reset mid-session, valid held
      drive(tbl[0]); push0(1, tbl[0].word); cyc();
      drive(tbl[2]); rst_n = 1'b0; #1;
      check("abort outputs", 64'({mem_we, busy, done, err, in_ready}), 64'd0);
      check("abort addr/count", 64'({mem_addr, count}), 64'd0);
      check("abort wdata", 64'(mem_wdata), 64'd0);
      cyc(); cyc(); rst_n = 1'b1;
      cyc(); cyc(); cyc();
      check("post-reset idle", 64'({busy, in_ready, done}), 64'd0);
      in_valid = 1'b0;

      // LAST_ADDR=3 instance: six words offered, four written
      start3 = 1'b1; cyc(); start3 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wr_t e;
         drive(tbl[k]);
         check($sformatf("last k%0d in_ready", k), 64'(in_ready3), 64'(k < 4));
         if (k < 4) begin
            e.addr = 8'(k); e.data = tbl[k].word;
            q3.push_back(e);
         end
         cyc();
      end
      in_valid = 1'b0; cyc();
      check("last done", 64'({done3, busy3}), 64'b10);
      check("last count", 64'(count3), 64'd4);
      check("last addr", 64'(mem_addr3), 64'd3);

      cyc();
      check("dut queue drained", 64'(q0.size()), 64'd0);
      check("dut3 queue drained", 64'(q3.size()), 64'd0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
